// File: rtl/arp_cache_query_arb_if.sv
// Query/response handshake bundle shared by the requester side (N lanes)
// and the cache side (a single lane). The arbiter is the slave of the
// requesters and the master towards the cache.
interface arp_cache_query_arb_if #(
  parameter int N = 1
);
  logic [N-1:0]    request_valid;
  logic [N-1:0]    request_ready;
  logic [N*32-1:0] request_ip;
  logic [N-1:0]    response_valid;
  logic [N-1:0]    response_ready;
  logic            response_error;
  logic [47:0]     response_mac;

  modport master (
    output request_valid, request_ip, response_ready,
    input  request_ready, response_valid, response_error, response_mac
  );

  modport slave (
    input  request_valid, request_ip, response_ready,
    output request_ready, response_valid, response_error, response_mac
  );
endinterface

// File: rtl/arp_cache_query_arb.sv
// Round-robin arbiter sharing one ARP cache query port among N_PORTS
// requesters. Exactly one query is in flight; the response (or a
// synthesised error after TIMEOUT_CYCLES) is routed back to its issuer.
module arp_cache_query_arb #(
  parameter int N_PORTS        = 3,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  arp_cache_query_arb_if.slave         s_query,
  arp_cache_query_arb_if.master        m_query,
  output logic                         busy,
  output logic [15:0]                  timeout_count
);

  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [GW-1:0]            LAST_RESET = GW'(N_PORTS - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [N_PORTS-1:0]       ONE_HOT0   = N_PORTS'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [GW-1:0]            last_grant_q, last_grant_d;
  logic [31:0]              ip_q, ip_d;
  logic                     err_q, err_d;
  logic [47:0]              mac_q, mac_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic [15:0]              tcount_q, tcount_d;
  logic [N_PORTS-1:0]       rsp_valid_q, rsp_valid_d;
  logic [N_PORTS-1:0]       req_ready_s;
  logic [GW-1:0]            sel_s;
  logic                     sel_found_s;

  // Round-robin pick: scan downward so the requester closest after last_grant_q wins.
  always_comb begin
    int idx;
    idx         = 0;
    sel_s       = '0;
    sel_found_s = |s_query.request_valid;
    for (int k = N_PORTS; k >= 1; k--) begin
      idx   = (int'(last_grant_q) + k) % N_PORTS;
      sel_s = s_query.request_valid[idx] ? GW'(idx) : sel_s;
    end
  end

  // Next-state logic for the single outstanding query.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ip_d         = ip_q;
    err_d        = err_q;
    mac_d        = mac_q;
    timer_d      = timer_q;
    tcount_d     = tcount_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready_s  = '0;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          req_ready_s = ONE_HOT0 << sel_s;
          grant_d     = sel_s;
          ip_d        = s_query.request_ip[32*int'(sel_s) +: 32];
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (m_query.request_ready[0]) begin
          timer_d = '0;
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        timer_d = timer_q + TIMEOUT_WIDTH'(1);
        // A real response beats a timeout landing in the same cycle.
        if (m_query.response_valid[0]) begin
          err_d       = m_query.response_error;
          mac_d       = m_query.response_mac;
          rsp_valid_d = ONE_HOT0 << grant_q;
          state_d     = DELIVER;
        end else if (timer_q == TIMER_LAST) begin
          err_d       = 1'b1;
          mac_d       = 48'h0;
          tcount_d    = (tcount_q == 16'hFFFF) ? tcount_q : tcount_q + 16'd1;
          rsp_valid_d = ONE_HOT0 << grant_q;
          state_d     = DELIVER;
        end else begin
          state_d = WAIT;
        end
      end
      DELIVER: begin
        if (s_query.response_ready[grant_q]) begin
          last_grant_d = grant_q;
          rsp_valid_d  = '0;
          state_d      = IDLE;
        end else begin
          state_d = DELIVER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RESET;
      ip_q         <= 32'h0;
      err_q        <= 1'b0;
      mac_q        <= 48'h0;
      timer_q      <= '0;
      tcount_q     <= 16'h0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ip_q         <= ip_d;
      err_q        <= err_d;
      mac_q        <= mac_d;
      timer_q      <= timer_d;
      tcount_q     <= tcount_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // Stale cache responses are accepted and dropped everywhere except DELIVER.
  assign s_query.request_ready  = req_ready_s;
  assign s_query.response_valid = rsp_valid_q;
  assign s_query.response_error = err_q;
  assign s_query.response_mac   = mac_q;
  assign m_query.request_valid  = (state_q == ISSUE);
  assign m_query.request_ip     = ip_q;
  assign m_query.response_ready = (state_q != DELIVER);
  assign busy                   = (state_q != IDLE);
  assign timeout_count          = tcount_q;

endmodule
